// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - load/scan inputs and multiplexed display outputs of seven_seg_scan
interface seven_seg_scan_if;
  logic        anode_signal;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;

  modport master (
    output anode_signal, load, value, dp_in,
    input  an, seg, dp, digit_sel
  );

  modport slave (
    input  anode_signal, load, value, dp_in,
    output an, seg, dp, digit_sel
  );
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit hex display scanner with dead-time blanking and double-buffered value
module seven_seg_scan #(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  seven_seg_scan_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [1:0] LAST_SEL  = 2'(DIGITS - 1);
  localparam logic [4:0] BLANK_LD  = 5'(BLANK_CYCLES);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] shadow_val_q, shadow_val_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        pending_q, pending_d;
  logic        anode_q;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        tick;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (bus.anode_signal != anode_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;

    if (bus.load) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp_in;
      pending_d    = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          disp_val_d = bus.value;
          disp_dp_d  = bus.dp_in;
          pending_d  = 1'b0;
          sel_d      = 2'd0;
          cnt_d      = BLANK_LD;
          state_d    = BLANK;
        end
      end
      BLANK: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (tick) begin
          state_d = BLANK;
          cnt_d   = BLANK_LD;
          if (sel_q == LAST_SEL) begin
            sel_d = 2'd0;
            // Frame boundary: swap in the buffered value; a load landing now waits for the next wrap.
            if (pending_q) begin
              disp_val_d = shadow_val_q;
              disp_dp_d  = shadow_dp_q;
              if (!bus.load) begin
                pending_d = 1'b0;
              end
            end
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next-state so they register in step with the state change.
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_d == DRIVE) begin
      an_d  = ~(4'b0001 << sel_d);
      seg_d = hex7(disp_val_d[{sel_d, 2'b00} +: 4]);
      dp_d  = ~disp_dp_d[sel_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      sel_q        <= 2'd0;
      disp_val_q   <= 16'd0;
      disp_dp_q    <= 4'd0;
      shadow_val_q <= 16'd0;
      shadow_dp_q  <= 4'd0;
      pending_q    <= 1'b0;
      anode_q      <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      anode_q      <= bus.anode_signal;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_sel = sel_q;

endmodule
